// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART buffer blocks: FSM encoding, byte width, line-rate defaults.
package uart_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 8;
    localparam int unsigned SYSTEM_CLOCK       = 32000000;
    localparam int unsigned BAUD_RATE          = 9600;
    localparam int unsigned STATE_W            = 2;

    // Width matches the uart_tx state_out_dbg port so debug views line up.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } txb_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_fifo_sync.sv
// Synchronous first-word-fall-through byte FIFO; full/empty are registered decodes of the stored count.
module uart_fifo_sync
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned CW        = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, empty_q;
    logic                  push_c, pop_c;

    // A pop never frees room for a push on the same edge: admission looks at the registered full.
    assign push_c = wr_en && !full_q;
    assign pop_c  = rd_en && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_c) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte buffer in front of uart_tx: drains one frame at a time over the en/data_in/rdy handshake.
// Define UART_TXB_DROPCNT_EN to add the saturating drop_cnt port for bytes pushed while full.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned EN_CYCLES  = 1,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned CW        = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count,
    input  logic                  tx_rdy,
    output logic                  tx_en,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy
`ifdef UART_TXB_DROPCNT_EN
    ,
    output logic [7:0]            drop_cnt
`endif
);

    localparam logic [7:0] HOLD_LAST = 8'(EN_CYCLES);

    txb_state_e            state_q;
    logic [7:0]            hold_q;
    logic                  tx_en_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  pop_c;

    uart_fifo_sync #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop_c),
        .rd_data (fifo_rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign pop_c = (state_q == ST_IDLE) && !empty && tx_rdy;

    // Handshake FSM; tx_data is latched at the pop and held until the frame completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            tx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            tx_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_c) begin
                        state_q   <= ST_START;
                        tx_data_q <= fifo_rd_data;
                        tx_en_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        hold_q    <= 8'd1;
                    end
                end
                ST_START: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q <= ST_WAIT_BUSY;
                        tx_en_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (!tx_rdy) state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (tx_rdy) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_en   = tx_en_q;
    assign tx_data = tx_data_q;
    assign busy    = busy_q;

`ifdef UART_TXB_DROPCNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (wr_en && full && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomized bench for uart_tx_buffer with a queue-based reference and a uart_tx stand-in driving tx_rdy.
module tb_uart_tx_buffer;
    import uart_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DW     = 8;
    localparam int unsigned EN_CYC = 4;
    localparam int unsigned AW     = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          tx_rdy = 1'b1;
    logic          full, empty, tx_en, busy;
    logic [AW:0]   count;
    logic [DW-1:0] tx_data;
`ifdef UART_TXB_DROPCNT_EN
    logic [7:0]    drop_cnt;
`endif

    always #5 clk = ~clk;

    uart_tx_buffer #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .EN_CYCLES  (EN_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .tx_rdy  (tx_rdy),
        .tx_en   (tx_en),
        .tx_data (tx_data),
        .busy    (busy)
`ifdef UART_TXB_DROPCNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a byte queue plus the transmit phase (0 idle, 1 enable, 2 await accept, 3 await done).
    logic [DW-1:0] mq[$];
    logic [DW-1:0] sent_q[$];
    logic [DW-1:0] m_data = '0;
    int            m_phase = 0;
    int            m_en_left = 0;
    int            m_drops = 0;
    bit            m_valid = 0;
    bit            was_full, do_pop;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            sent_q.delete();
            m_phase   = 0;
            m_en_left = 0;
            m_data    = '0;
            m_drops   = 0;
            m_valid   = 1;
        end else begin
            was_full = (mq.size() == DEPTH);
            do_pop   = (m_phase == 0) && (mq.size() != 0) && tx_rdy;
            if (wr_en && was_full && m_drops < 255) m_drops++;
            case (m_phase)
                1: begin
                    m_en_left--;
                    if (m_en_left == 0) m_phase = 2;
                end
                2: if (!tx_rdy) m_phase = 3;
                3: if (tx_rdy) m_phase = 0;
                default: ;
            endcase
            if (do_pop) begin
                m_data = mq.pop_front();
                sent_q.push_back(m_data);
                m_phase   = 1;
                m_en_left = EN_CYC;
            end
            if (wr_en && !was_full) mq.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("count",   32'(count),   32'(mq.size()));
            chk("empty",   32'(empty),   32'(mq.size() == 0));
            chk("full",    32'(full),    32'(mq.size() == DEPTH));
            chk("busy",    32'(busy),    32'(m_phase != 0));
            chk("tx_en",   32'(tx_en),   32'(m_phase == 1));
            chk("tx_data", 32'(tx_data), 32'(m_data));
`ifdef UART_TXB_DROPCNT_EN
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
        end
    end

    // uart_tx stand-in: takes the byte on tx_en, drops rdy after a delay, stays busy for a frame time.
    int            st = 0;
    int            cnt = 0;
    int            acc_delay = 0;
    int            busy_len = 8;
    bit            rand_timing = 1;
    bit            hold_low = 0;
    logic [DW-1:0] rx_log[$];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                st = 0;
                tx_rdy = 1'b1;
            end else if (hold_low) begin
                tx_rdy = 1'b0;
            end else begin
                if (st == 0) tx_rdy = 1'b1;
                if (st == 0 && tx_en) begin
                    rx_log.push_back(tx_data);
                    if (sent_q.size() == 0) chk("rx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
                    else chk("rx_order", 32'(tx_data), 32'(sent_q.pop_front()));
                    cnt = rand_timing ? int'($urandom_range(0, 6)) : acc_delay;
                    st = 1;
                end
                if (st == 1) begin
                    if (cnt == 0) begin
                        tx_rdy = 1'b0;
                        cnt = rand_timing ? int'($urandom_range(6, 12)) : busy_len;
                        st = 2;
                    end else cnt--;
                end else if (st == 2) begin
                    if (cnt == 0) begin
                        tx_rdy = 1'b1;
                        st = 0;
                    end else cnt--;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk); #1;
            ok = (mq.size() == 0) && (m_phase == 0) && (st == 0);
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // Pushes one byte into an idle buffer and checks the two-clock latency and enable length.
    task automatic measure_frame(input logic [DW-1:0] b, output int len);
        @(posedge clk); #1 wr_en = 1'b1; wr_data = b;
        @(posedge clk); #1 wr_en = 1'b0;
        @(negedge clk);
        chk("lat_first_edge_en", 32'(tx_en), 32'd0);
        chk("lat_first_edge_cnt", 32'(count), 32'd1);
        @(negedge clk);
        chk("lat_second_edge_en", 32'(tx_en), 32'd1);
        chk("lat_second_edge_data", 32'(tx_data), 32'(b));
        len = 0;
        for (int i = 0; i < int'(EN_CYC) + 10; i++) begin
            if (tx_en) len++;
            @(negedge clk);
        end
    endtask

    initial begin
        int len;
        logic [DW-1:0] pat2 [3];
        pat2[0] = 8'h55; pat2[1] = 8'h03; pat2[2] = 8'hA7;

        do_reset();
        @(negedge clk);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_tx_en", 32'(tx_en), 32'd0);

        // Single byte: latency and enable width.
        wait_idle();
        rx_log.delete();
        measure_frame(8'h55, len);
        chk("t1_en_len", 32'(len), 32'(EN_CYC));
        wait_idle();
        chk("t1_rx", 32'(rx_log.size() == 1 ? rx_log[0] : 8'h00), 32'h55);

        // Three bytes queued behind a busy transmitter, then drained in order.
        hold_low = 1;
        repeat (2) @(posedge clk);
        rx_log.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 wr_en = 1'b1; wr_data = pat2[i];
            @(negedge clk); chk("t2_count_up", 32'(count), 32'(i));
        end
        @(posedge clk); #1 wr_en = 1'b0;
        @(negedge clk); chk("t2_count_3", 32'(count), 32'd3);
        hold_low = 0;
        wait_idle();
        chk("t2_rx_n", 32'(rx_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < rx_log.size(); i++) chk("t2_rx", 32'(rx_log[i]), 32'(pat2[i]));

        // Overfill while the transmitter is stalled.
        do_reset();
        hold_low = 1;
        repeat (2) @(posedge clk);
        rx_log.delete();
        for (int i = 0; i < int'(DEPTH) + 3; i++) begin
            @(posedge clk); #1 wr_en = 1'b1; wr_data = 8'(8'h80 + i);
        end
        @(posedge clk); #1 wr_en = 1'b0;
        @(negedge clk);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_count", 32'(count), 32'(DEPTH));
`ifdef UART_TXB_DROPCNT_EN
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd3);
`endif
        hold_low = 0;
        wait_idle();
        @(negedge clk);
        chk("t3_empty", 32'(empty), 32'd1);
        chk("t3_rx_n", 32'(rx_log.size()), 32'(DEPTH));
        for (int i = 0; i < rx_log.size(); i++) chk("t3_rx", 32'(rx_log[i]), 32'(8'h80 + i));

        // Pointer wrap: 2*DEPTH+1 distinct bytes, pushed only when room exists.
        rx_log.delete();
        for (int b = 0; b <= 2 * int'(DEPTH); b++) begin
            int g = 0;
            while (mq.size() >= DEPTH && g < 5000) begin
                wr_en = 1'b0;
                @(posedge clk); #1;
                g++;
            end
            wr_en = 1'b1; wr_data = 8'(b);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        wait_idle();
        chk("t4_rx_n", 32'(rx_log.size()), 32'(2 * DEPTH + 1));
        for (int i = 0; i < rx_log.size(); i++) chk("t4_rx", 32'(rx_log[i]), 32'(i));

        // Random traffic with random transmitter timing.
        rand_timing = 1;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            wr_en = ($urandom_range(0, 99) < 30);
            wr_data = 8'($urandom);
        end
        wr_en = 1'b0;
        wait_idle();

        // Reset while waiting for the frame to finish with bytes queued.
        rand_timing = 0; acc_delay = 0; busy_len = 30;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
        end
        @(posedge clk); #1 wr_en = 1'b0;
        begin
            bit seen = 0;
            for (int i = 0; i < 100 && !seen; i++) begin
                if (m_phase == 3) seen = 1;
                else begin @(posedge clk); #1; end
            end
            chk("t5_reach_wait_done", 32'(seen), 32'd1);
        end
        chk("t5_model_queued", 32'(mq.size()), 32'd4);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_tx_en", 32'(tx_en), 32'd0);
        len = 0;
        repeat (40) begin @(negedge clk); if (tx_en) len++; end
        chk("t5_no_en_after_rst", 32'(len), 32'd0);

        // Enable held EN_CYC clocks; accept arriving mid-enable and after enable ends.
        busy_len = 8;
        acc_delay = 3;
        wait_idle();
        measure_frame(8'h3C, len);
        chk("t6_en_len_d3", 32'(len), 32'(EN_CYC));
        wait_idle();
        acc_delay = 7;
        measure_frame(8'hC3, len);
        chk("t6_en_len_d7", 32'(len), 32'(EN_CYC));
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Byte FIFO that sits directly upstream of uart_tx.
- Accepts bytes from a producer at clock rate and buffers them.
- Drains the buffer into uart_tx one frame at a time, using uart_tx's en/data_in/rdy handshake.
- Lets a producer burst data without tracking serial-line timing.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of two, >= 2. AW = $clog2(DEPTH).
- DATA_WIDTH, 8: width of a byte lane; matches uart_tx data_in.
- EN_CYCLES, 1: number of consecutive clocks tx_en is held high per byte; range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  push request, one byte per cycle.
- wr_data  in  DATA_WIDTH  byte to push.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  AW+1  bytes currently stored, excluding the byte in flight.
- tx_rdy  in  1  uart_tx rdy; high = transmitter idle.
- tx_en  out  1  uart_tx en.
- tx_data  out  DATA_WIDTH  uart_tx data_in.
- busy  out  1  FSM not in IDLE.
- drop_cnt  out  8  only with UART_TXB_DROPCNT_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - Pointers and count are 0; full=0, empty=1.
  - tx_en=0, tx_data=0, busy=0, FSM in IDLE, drop_cnt=0.
- Push:
  - On a clock edge with wr_en=1 and full=0, the word is written at wr_ptr, wr_ptr increments, and count increments.
  - wr_en=1 with full=1 drops the byte; FIFO state is unchanged.
  - full is evaluated from the registered count. A pop in the same cycle does not admit a push into a full FIFO.
- Pointers: AW bits each, wrap from DEPTH-1 to 0.
- Simultaneous push and pop (not full): count is unchanged; both pointers advance.
- FSM (registered):
  - IDLE:
    - If empty=0 and tx_rdy=1, go to START.
    - On the same edge, tx_data <= mem[rd_ptr], rd_ptr++, count--.
    - A byte pushed into an empty FIFO is not visible to the FSM until the next cycle.
  - START:
    - tx_en=1 for EN_CYCLES clocks, counted by an 8-bit hold counter.
    - Then go to WAIT_BUSY.
  - WAIT_BUSY: tx_en=0. When tx_rdy=0 (transmitter accepted the byte), go to WAIT_DONE.
  - WAIT_DONE: when tx_rdy=1, go to IDLE.
- Output rules:
  - tx_data is stable from the START entry edge until IDLE is re-entered.
  - tx_en is a registered decode of the START state only.
- Latency: with an empty FIFO, IDLE state, and tx_rdy=1, a push on edge N gives tx_en=1 during the cycle after edge N+1 (2 clocks).
- Back-to-back bytes: the next pop happens no earlier than the cycle after tx_rdy returns high.
- Reset mid-operation:
  - The FIFO is flushed and the in-flight byte is abandoned.
  - tx_en is 0 in the cycle after the rst edge.
- Default case: any illegal state returns to IDLE.

Optional Feature:
- Macro: UART_TXB_DROPCNT_EN.
- Defined:
  - drop_cnt port exists.
  - It increments on every push attempt made while full=1.
  - It saturates at 255 and is cleared only by rst.
- Undefined: the port and counter are absent. Dropped bytes are silently discarded with no other behavioural difference.

Decomposition:
- Package uart_pkg holds:
  - FSM state encoding (IDLE, START, WAIT_BUSY, WAIT_DONE; 2 bits, matching the uart_tx state_out_dbg width).
  - Default DATA_WIDTH=8.
  - SYSTEM_CLOCK/BAUD_RATE defaults of 32000000/9600.
- One sub-module: uart_fifo_sync.
  - Storage, pointers, count, full/empty.
  - Ports wr_en/wr_data/rd_en/rd_data.
  - Can be reused by a future uart_rx-side buffer.
- FSM and handshake stay in uart_tx_buffer.

Test Plan:
1. Reset with uart_tx instantiated, then push 8'h55 once. Required: tx_en high for exactly EN_CYCLES clocks two clocks later, tx_data=8'h55, and uart_rx reports valid with rx_data=8'h55.
2. Push 8'h55, 8'h03, 8'hA7 in consecutive cycles. Required: count goes 1,2,3 then decrements; uart_rx receives 55, 03, A7 in order, with no second tx_en while tx_rdy=0.
3. Push DEPTH+3 bytes with tx_rdy held low by a stub. Required: full=1 after DEPTH pushes, the 3 extra bytes are dropped, and drop_cnt=3 when the macro is defined. Then release tx_rdy: exactly DEPTH bytes drain, and empty=1 at the end.
4. Pointer wrap: push and drain 2*DEPTH+1 distinct bytes (00..20 hex). Required: output order matches input order exactly across the wrap.
5. Assert rst while in WAIT_DONE with 4 bytes queued. Required: next cycle empty=1, count=0, busy=0, tx_en=0, and no further tx_en until a new push.
6. Set EN_CYCLES=4 with a stub that drops tx_rdy only after 3 en cycles. Required: tx_en high for exactly 4 clocks and the FSM waits in WAIT_BUSY until tx_rdy falls.
